sd_spi: RTL and testbench

SPI master byte engine for the RK8E SD-card disk emulation. A higher-level SD protocol controller drives it with one-cycle opcodes to select or deselect the card, choose the slow (initialisation) or fast (data) bit rate, and shift full bytes. It implements SPI mode 0, MSB first, and reports completion of each byte transfer with a one-cycle done pulse.

---
 rtl/sd_types.sv | 4 +
 rtl/sdspi_types.sv | 14 +
 rtl/sdspi_clkdiv.sv | 29 ++
 rtl/sd_spi.sv | 114 +++++++++++
 tb/tb_sd_spi.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_types.sv
// Shared data types for the RK8E SD-card emulation.
package sd_types;
  typedef logic [7:0] sdBYTE_t;
endpackage

// File: rtl/sdspi_types.sv
// Opcode set understood by the sd_spi byte engine.
package sdspi_types;
  // Codes 6 and 7 are unused and decode as NOP.
  typedef enum logic [2:0] {
    spiNOP  = 3'd0,
    spiCSL  = 3'd1,
    spiCSH  = 3'd2,
    spiFAST = 3'd3,
    spiSLOW = 3'd4,
    spiTR   = 3'd5
  } spiOP_t;

  localparam int SPI_DIV_W = 16;
endpackage

// File: rtl/sdspi_clkdiv.sv
// Loadable down-counter producing one tick every div clocks while enabled;
// a load restarts the count so the first tick lands exactly div clocks later.
module sdspi_clkdiv
  import sdspi_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [SPI_DIV_W-1:0] div,
  output logic                 tick
);

  logic [SPI_DIV_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load || tick)
      cnt <= div - SPI_DIV_W'(1);
    else if (en)
      cnt <= cnt - SPI_DIV_W'(1);
  end

endmodule

// File: rtl/sd_spi.sv
// SPI mode-0 master byte engine: CS and bit-rate control plus MSB-first
// byte shifting, driven by one-cycle opcodes from the SD protocol controller.
module sd_spi
  import sd_types::*;
  import sdspi_types::*;
#(
  parameter int SLOW_DIV = 128,
  parameter int FAST_DIV = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  spiOP_t  spiOP,
  input  sdBYTE_t spiTXD,
  output sdBYTE_t spiRXD,
  output logic    spiCS,
  output logic    spiDONE,
  output logic    spiMOSI,
  input  logic    spiMISO,
  output logic    spiSCLK
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state, stateNext;
  logic                 fastMode;
  logic                 accept;
  logic                 tick;
  logic                 lastEdge;
  logic [3:0]           halfCnt;
  sdBYTE_t              txSh;
  sdBYTE_t              rxSh;
  logic [SPI_DIV_W-1:0] divSel;

  assign divSel   = fastMode ? SPI_DIV_W'(FAST_DIV) : SPI_DIV_W'(SLOW_DIV);
  assign lastEdge = tick && (halfCnt == 4'd15);

  sdspi_clkdiv u_clkdiv (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (state == XFER),
    .div  (divSel),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // NOTE: defaults first keep every path assigned, so no latch is inferred.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (spiOP == spiTR) begin
        accept    = 1'b1;
        stateNext = XFER;
      end
      XFER: if (lastEdge) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Even half-period ticks raise SCLK and sample MISO; odd ones lower it and
  // present the next TX bit, except the last which completes the byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spiCS    <= 1'b1;
      spiSCLK  <= 1'b0;
      spiMOSI  <= 1'b1;
      spiRXD   <= '0;
      spiDONE  <= 1'b0;
      fastMode <= 1'b0;
      halfCnt  <= '0;
      txSh     <= '0;
      rxSh     <= '0;
    end else begin
      spiDONE <= 1'b0;
      if (state == IDLE) begin
        case (spiOP)
          spiCSL:  spiCS    <= 1'b0;
          spiCSH:  spiCS    <= 1'b1;
          spiFAST: fastMode <= 1'b1;
          spiSLOW: fastMode <= 1'b0;
          spiTR: begin
            txSh    <= spiTXD;
            spiMOSI <= spiTXD[7];
            spiSCLK <= 1'b0;
            halfCnt <= '0;
          end
          default: ;
        endcase
      end else if (tick) begin
        halfCnt <= halfCnt + 4'd1;
        if (!halfCnt[0]) begin
          spiSCLK <= 1'b1;
          rxSh    <= {rxSh[6:0], spiMISO};
        end else begin
          spiSCLK <= 1'b0;
          if (lastEdge) begin
            spiRXD  <= rxSh;
            spiDONE <= 1'b1;
            spiMOSI <= 1'b1;
          end else begin
            txSh    <= {txSh[6:0], 1'b0};
            spiMOSI <= txSh[6];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi.sv
// Scoreboard bench for sd_spi: expected bytes, MOSI patterns and latencies
// are queued at each accept and compared when spiDONE pulses.
module tb_sd_spi;
  import sd_types::*;
  import sdspi_types::*;

  localparam int SLOW = 128;
  localparam int FAST = 2;

  logic    clk;
  logic    rst;
  spiOP_t  spiOP;
  sdBYTE_t spiTXD;
  sdBYTE_t spiRXD;
  logic    spiCS;
  logic    spiDONE;
  logic    spiMOSI;
  logic    spiMISO;
  logic    spiSCLK;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         t0;
    int         lat;
  } exp_t;

  exp_t       sbQ[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         doneCnt = 0;
  int         riseCnt = 0;
  int         expDone = 0;
  logic [7:0] misoPat = 8'h00;
  logic [7:0] monBits;
  logic [3:0] bitCnt;
  logic       prevSclk;
  logic       lenPending;

  sd_spi #(.SLOW_DIV(SLOW), .FAST_DIV(FAST)) dut (
    .clk     (clk),
    .rst     (rst),
    .spiOP   (spiOP),
    .spiTXD  (spiTXD),
    .spiRXD  (spiRXD),
    .spiCS   (spiCS),
    .spiDONE (spiDONE),
    .spiMOSI (spiMOSI),
    .spiMISO (spiMISO),
    .spiSCLK (spiSCLK)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: collects MOSI at SCLK rises, feeds the MISO pattern, scores DONE.
  always @(negedge clk) begin
    if (rst) begin
      bitCnt     = '0;
      monBits    = '0;
      prevSclk   = 1'b0;
      lenPending = 1'b0;
      spiMISO    = misoPat[7];
    end else begin
      if (lenPending) begin
        chk("done_1cyc", 32'(spiDONE), 32'd0);
        lenPending = 1'b0;
      end
      if (spiSCLK && !prevSclk) begin
        monBits = {monBits[6:0], spiMOSI};
        bitCnt  = bitCnt + 4'd1;
        riseCnt++;
      end
      prevSclk = spiSCLK;
      if (spiDONE) begin
        if (sbQ.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          chk("rxd", 32'(spiRXD), 32'(e.rx));
          chk("mosi_bits", 32'(monBits), 32'(e.tx));
          chk("rise_count", 32'(bitCnt), 32'd8);
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("mosi_idle", 32'(spiMOSI), 32'd1);
          chk("sclk_idle", 32'(spiSCLK), 32'd0);
        end
        doneCnt++;
        lenPending = 1'b1;
        bitCnt     = '0;
        monBits    = '0;
      end
      spiMISO = (bitCnt < 4'd8) ? misoPat[3'(4'd7 - bitCnt)] : 1'b0;
    end
  end

  task automatic doOp(input spiOP_t op);
    @(negedge clk);
    spiOP = op;
    @(negedge clk);
    spiOP = spiNOP;
  endtask

  task automatic startXfer(input logic [7:0] tx, input logic [7:0] pat, input int d);
    @(negedge clk);
    misoPat = pat;
    @(negedge clk);
    spiTXD = tx;
    spiOP  = spiTR;
    @(negedge clk);
    spiOP = spiNOP;
    sbQ.push_back('{rx: pat, tx: tx, t0: cyc, lat: 16 * d});
    expDone++;
  endtask

  task automatic waitDone(input int target, input int budget);
    int n = 0;
    while (doneCnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (doneCnt < target) chk("done_timeout", 32'(doneCnt), 32'(target));
  endtask

  initial begin
    int c;
    int snapDone;
    int snapRise;
    rst    = 1'b1;
    spiOP  = spiCSL;
    spiTXD = 8'h00;

    // Reset holds outputs at reset values and ignores the CSL opcode.
    repeat (4) @(negedge clk);
    chk("rst_cs", 32'(spiCS), 32'd1);
    chk("rst_sclk", 32'(spiSCLK), 32'd0);
    chk("rst_mosi", 32'(spiMOSI), 32'd1);
    chk("rst_rxd", 32'(spiRXD), 32'd0);
    chk("rst_done", 32'(spiDONE), 32'd0);
    spiOP = spiNOP;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Chip select toggling without any transfer activity.
    snapDone = doneCnt;
    snapRise = riseCnt;
    doOp(spiCSL);
    chk("cs_low", 32'(spiCS), 32'd0);
    doOp(spiCSH);
    chk("cs_high", 32'(spiCS), 32'd1);
    repeat (4) @(negedge clk);
    chk("cs_no_sclk", 32'(riseCnt), 32'(snapRise));
    chk("cs_no_done", 32'(doneCnt), 32'(snapDone));

    // Slow transfer.
    doOp(spiSLOW);
    startXfer(8'h55, 8'h00, SLOW);
    waitDone(expDone, 16 * SLOW + 50);

    // Fast transfers, CS held low across them.
    doOp(spiFAST);
    doOp(spiCSL);
    startXfer(8'hAA, 8'hFF, FAST);
    waitDone(expDone, 16 * FAST + 50);
    startXfer(8'h5A, 8'hC3, FAST);
    waitDone(expDone, 16 * FAST + 50);
    chk("cs_kept_low", 32'(spiCS), 32'd0);

    // spiTR held continuously: each accept one cycle after the previous DONE.
    @(negedge clk);
    misoPat = 8'h69;
    @(negedge clk);
    spiTXD = 8'h96;
    spiOP  = spiTR;
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < 3; i++)
      sbQ.push_back('{rx: 8'h69, tx: 8'h96, t0: c + i * (16 * FAST + 1), lat: 16 * FAST});
    waitDone(expDone + 2, 2 * (16 * FAST + 1) + 50);
    @(negedge clk);
    spiOP = spiNOP;
    expDone += 3;
    waitDone(expDone, 16 * FAST + 50);
    repeat (16 * FAST + 10) @(negedge clk);
    chk("b2b_stopped", 32'(doneCnt), 32'(expDone));

    // Reset after three SCLK pulses with MISO 1,0,1 aborts the transfer.
    startXfer(8'h81, 8'hA0, FAST);
    begin
      int n = 0;
      while (bitCnt != 4'd3 && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("mid_reach_3", 32'(bitCnt), 32'd3);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("mid_cs", 32'(spiCS), 32'd1);
    chk("mid_sclk", 32'(spiSCLK), 32'd0);
    chk("mid_mosi", 32'(spiMOSI), 32'd1);
    chk("mid_rxd", 32'(spiRXD), 32'd0);
    chk("mid_done", 32'(spiDONE), 32'd0);
    snapDone = doneCnt;
    sbQ.delete();
    expDone--;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (16 * FAST + 20) @(negedge clk);
    chk("mid_no_done", 32'(doneCnt), 32'(snapDone));
    chk("mid_rxd_after", 32'(spiRXD), 32'd0);

    // Busy rejection; speed is back to slow after reset, so no spiSLOW here.
    chk("busy_cs_pre", 32'(spiCS), 32'd1);
    startXfer(8'h3C, 8'h96, SLOW);
    repeat (300) @(negedge clk);
    doOp(spiCSL);
    doOp(spiFAST);
    spiTXD = 8'h12;
    doOp(spiTR);
    chk("busy_cs", 32'(spiCS), 32'd1);
    waitDone(expDone, 16 * SLOW + 50);
    startXfer(8'hF0, 8'h0F, SLOW);
    waitDone(expDone, 16 * SLOW + 50);
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sbQ.size()), 32'd0);
    chk("done_total", 32'(doneCnt), 32'(expDone));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
